// File: rtl/median_pkg.sv
// Shared types and constants for the streaming 5-tap median filter.
// Holds the controller state encoding, the default sample width and the window length.
package median_pkg;

  localparam int DATA_W_DEFAULT = 6;
  localparam int WIN_LEN        = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/median5.sv
// Combinational median of five unsigned samples (third smallest), no state.
// This is a 9-comparator sorting network, pruned to the paths that feed the middle output.
module median5 #(
  parameter int DATA_W = 6
) (
  input  logic [4:0][DATA_W-1:0] din,
  output logic [DATA_W-1:0]      med
);

  function automatic logic [DATA_W-1:0] mn(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] mx(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  logic [DATA_W-1:0] a0, a1, a2, a3, a4;
  logic [DATA_W-1:0] b0, b1, b2, b3, b4;
  logic [DATA_W-1:0] c1, c2, c4;
  logic [DATA_W-1:0] e2, e3;

  // Layers: (0,3)(1,4) / (0,2)(1,3) / (0,1)(2,4) / (1,2)(3,4) / (2,3)
  assign a0 = mn(din[0], din[3]);
  assign a3 = mx(din[0], din[3]);
  assign a1 = mn(din[1], din[4]);
  assign a4 = mx(din[1], din[4]);
  assign a2 = din[2];

  assign b0 = mn(a0, a2);
  assign b2 = mx(a0, a2);
  assign b1 = mn(a1, a3);
  assign b3 = mx(a1, a3);
  assign b4 = a4;

  assign c1 = mx(b0, b1);
  assign c2 = mn(b2, b4);
  assign c4 = mx(b2, b4);

  assign e2 = mx(c1, c2);
  assign e3 = mn(b3, c4);

  assign med = mn(e2, e3);

endmodule

// File: rtl/median_stream_ctrl.sv
// Framed sliding-window median: one median per sample once 5 are held, registered 1 cycle later.
// Backpressure: in_ready = !out_valid || out_ready, no skid buffer; output holds while stalled.
module median_stream_ctrl
  import median_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int WIN    = WIN_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_num,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_num,
  output logic              out_last,
  output logic              short_frame
);

  localparam logic [2:0] CNT_FULL = 3'(WIN);
  localparam logic [2:0] CNT_PRE  = 3'(WIN - 1);

  state_t                        state;
  logic [2:0]                    count;
  // The oldest entry leaves on every shift, so the window is the incoming
  // sample plus the WIN-1 newest held entries; only those need storage.
  logic [WIN-2:0][DATA_W-1:0]    hist;
  logic [WIN-1:0][DATA_W-1:0]    win_nxt;
  logic [DATA_W-1:0]             med;
  logic                          accept;
  logic                          produce;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign win_nxt  = {hist, in_num};
  assign produce  = accept && ((state == RUN) || (state == FILL && count == CNT_PRE));

  median5 #(.DATA_W(DATA_W)) u_median5 (
    .din (win_nxt),
    .med (med)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 3'd0;
      hist        <= '0;
      out_valid   <= 1'b0;
      out_num     <= '0;
      out_last    <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      short_frame <= 1'b0;
      if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        hist <= win_nxt[WIN-2:0];

        if (produce) begin
          out_valid <= 1'b1;
          out_num   <= med;
          out_last  <= in_last;
        end

        if (in_last) begin
          // Frame boundary: forget every held sample so frames never mix.
          state <= IDLE;
          count <= 3'd0;
          hist  <= '0;
          if (!produce) begin
            short_frame <= 1'b1;
          end
        end else begin
          case (state)
            IDLE: begin
              state <= FILL;
              count <= 3'd1;
            end
            FILL: begin
              count <= count + 3'd1;
              if (count == CNT_PRE) begin
                state <= RUN;
              end
            end
            RUN: begin
              count <= CNT_FULL;
            end
            default: begin
              state <= IDLE;
              count <= 3'd0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_median_stream_ctrl.sv
// Self-checking bench: directed frames plus randomized traffic against a queue-based median model.
module tb_median_stream_ctrl;

  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_num = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_num;
  logic          out_last;
  logic          short_frame;

  always #5 clk = ~clk;

  median_stream_ctrl #(.DATA_W(DW), .WIN(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_num      (in_num),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_num     (out_num),
    .out_last    (out_last),
    .short_frame (short_frame)
  );

  int n_chk = 0;
  int n_fail = 0;

  int fq[$];          // samples of the current frame accepted so far
  int exp_num[$];
  bit exp_last[$];
  int got_num[$];
  bit got_last[$];
  int frm[$];
  bit sf_exp = 1'b0;
  int n_short = 0;
  bit hold = 1'b0;
  int hold_num = 0;
  bit hold_last = 1'b0;
  int stall_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int median_last5();
    int w[$];
    for (int i = fq.size() - 5; i < fq.size(); i++) w.push_back(fq[i]);
    w.sort();
    return w[2];
  endfunction

  task automatic model_clear();
    fq.delete();
    exp_num.delete();
    exp_last.delete();
    sf_exp = 1'b0;
    hold = 1'b0;
  endtask

  // One cycle: check what the last edge produced, drive, then account for the coming edge.
  task automatic step(input bit v, input int n, input bit l, input bit r, output bit acc);
    bit rr;
    @(negedge clk);
    chk("short_frame", short_frame, sf_exp);
    if (short_frame) n_short++;
    sf_exp = 1'b0;
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_num", out_num, hold_num);
      chk("hold_last", out_last, hold_last);
    end
    rr = r;
    if (stall_left > 0 && out_valid) begin
      rr = 1'b0;
      stall_left--;
    end
    in_valid  = v;
    in_num    = DW'(n);
    in_last   = l;
    out_ready = rr;
    #1;
    chk("in_ready", in_ready, !out_valid || out_ready);
    chk("out_valid", out_valid, exp_num.size() != 0);
    acc = in_valid && in_ready;
    hold = out_valid && !out_ready;
    hold_num = out_num;
    hold_last = out_last;
    if (out_valid && out_ready && exp_num.size() != 0) begin
      chk("out_num", out_num, exp_num.pop_front());
      chk("out_last", out_last, exp_last.pop_front());
      got_num.push_back(int'(out_num));
      got_last.push_back(out_last);
    end
    if (acc) begin
      fq.push_back(int'(in_num));
      if (fq.size() >= 5) begin
        exp_num.push_back(median_last5());
        exp_last.push_back(l);
      end
      if (l) begin
        if (fq.size() < 5) sf_exp = 1'b1;
        fq.delete();
      end
    end
  endtask

  task automatic send_frame(input bit rnd);
    bit acc;
    int tries;
    for (int i = 0; i < frm.size(); i++) begin
      tries = 0;
      do begin
        step(rnd ? ($urandom_range(3) != 0) : 1'b1, frm[i], i == frm.size() - 1,
             rnd ? ($urandom_range(9) < 7) : 1'b1, acc);
        tries++;
      end while (!acc && tries < 100);
      if (!acc) chk("accept_timeout", 0, 1);
    end
  endtask

  task automatic drain();
    bit acc;
    int tries = 0;
    while ((exp_num.size() != 0 || hold) && tries < 50) begin
      step(1'b0, 0, 1'b0, 1'b1, acc);
      tries++;
    end
    step(1'b0, 0, 1'b0, 1'b1, acc);
    chk("drain_empty", exp_num.size(), 0);
  endtask

  initial begin
    bit acc;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_num", out_num, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_short", short_frame, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single full frame
    frm = '{7, 3, 9, 1, 5};
    got_num.delete(); got_last.delete();
    send_frame(1'b0);
    drain();
    chk("f1_count", got_num.size(), 1);
    if (got_num.size() == 1) begin
      chk("f1_val", got_num[0], 5);
      chk("f1_last", got_last[0], 1);
    end

    // Sliding window over a longer frame
    frm = '{10, 20, 30, 40, 50, 60, 0};
    got_num.delete(); got_last.delete();
    send_frame(1'b0);
    drain();
    chk("f2_count", got_num.size(), 3);
    if (got_num.size() == 3) begin
      chk("f2_v0", got_num[0], 30);
      chk("f2_v1", got_num[1], 40);
      chk("f2_v2", got_num[2], 40);
      chk("f2_l0", got_last[0], 0);
      chk("f2_l1", got_last[1], 0);
      chk("f2_l2", got_last[2], 1);
    end

    // Short frame then a clean frame
    frm = '{4, 8, 2};
    got_num.delete(); got_last.delete();
    n_short = 0;
    send_frame(1'b0);
    drain();
    chk("f3_short_pulses", n_short, 1);
    chk("f3_no_output", got_num.size(), 0);
    frm = '{1, 1, 1, 1, 1};
    send_frame(1'b0);
    drain();
    chk("f3b_count", got_num.size(), 1);
    if (got_num.size() == 1) chk("f3b_val", got_num[0], 1);

    // Backpressure: three stalled cycles on the first median
    frm = '{5, 1, 4, 2, 3, 9, 8, 7, 6};
    got_num.delete(); got_last.delete();
    stall_left = 3;
    send_frame(1'b0);
    drain();
    chk("f4_stall_used", stall_left, 0);
    chk("f4_count", got_num.size(), 5);
    if (got_num.size() == 5) begin
      chk("f4_v0", got_num[0], 3);
      chk("f4_v1", got_num[1], 3);
      chk("f4_v2", got_num[2], 4);
      chk("f4_v3", got_num[3], 7);
      chk("f4_v4", got_num[4], 7);
    end

    // Reset mid-frame
    for (int i = 0; i < 3; i++) step(1'b1, 11 + i, 1'b0, 1'b1, acc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_num", out_num, 0);
    chk("mrst_out_last", out_last, 0);
    chk("mrst_short", short_frame, 0);
    chk("mrst_in_ready", in_ready, 1);
    model_clear();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0, 1'b1, acc);
    frm = '{63, 0, 63, 0, 63};
    got_num.delete(); got_last.delete();
    send_frame(1'b0);
    drain();
    chk("f5_count", got_num.size(), 1);
    if (got_num.size() == 1) chk("f5_val", got_num[0], 63);

    // Randomized frames with valid gaps and random backpressure
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(12, 1);
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(int'($urandom_range(63)));
      send_frame(1'b1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/median_stream_ctrl.md
MEDIAN_STREAM_CTRL -- requirements
Module: median_stream_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 6, sample width in bits.
REQ-002 The block SHALL have parameter WIN, default 5, window length; only 5 is supported.
REQ-003 Port clk, input, 1: the single clock; all state changes on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1: in_num holds a sample.
REQ-006 Port in_ready, output, 1: block can accept a sample this cycle.
REQ-007 Port in_num, input, DATA_W: unsigned sample.
REQ-008 Port in_last, input, 1: the accepted sample is the last of its frame.
REQ-009 Port out_valid, output, 1: out_num holds a median.
REQ-010 Port out_ready, input, 1: downstream accepts out_num this cycle.
REQ-011 Port out_num, output, DATA_W: median of the 5 most recent samples of the frame.
REQ-012 Port out_last, output, 1: qualifies out_num as the frame's final median.
REQ-013 Port short_frame, output, 1: one-cycle pulse; frame ended with fewer than 5 samples.

Function
REQ-014 A sample SHALL be accepted on a cycle where in_valid and in_ready are both 1.
REQ-015 in_ready SHALL equal (!out_valid || out_ready); no skid buffer.
REQ-016 The block SHALL hold a 5-entry shift window; each accepted sample shifts in and the oldest entry is discarded.
REQ-017 The FSM SHALL have states IDLE (0 samples held), FILL (1-4 held) and RUN (5 held).
REQ-018 IDLE -> FILL on acceptance without in_last.
REQ-019 FILL -> RUN on acceptance of the 5th sample.
REQ-020 RUN SHALL stay in RUN on each accepted sample without in_last.
REQ-021 Any state -> IDLE on acceptance with in_last; the window count clears to 0.
REQ-022 In RUN, or on the 5th acceptance, the median of the updated window SHALL be registered into out_num with out_valid=1 on the next cycle (latency 1).
REQ-023 out_valid, out_num and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 out_valid SHALL clear after a cycle with out_ready=1, unless a new sample is accepted in the same cycle; in that case it stays 1 with the new median (back-to-back throughput 1/cycle).
REQ-025 out_last SHALL be 1 iff the produced median came from a sample accepted with in_last.
REQ-026 A sample accepted with in_last while fewer than 5 samples are held after shifting SHALL produce no output and SHALL pulse short_frame for 1 cycle, 1 cycle after acceptance.
REQ-027 Medians from different frames SHALL never mix: after in_last, the next frame restarts from IDLE.
REQ-028 Ties SHALL resolve by value only; the median is the 3rd smallest of the 5, unsigned compare.
REQ-029 in_last with in_valid=0, or while in_ready=0, SHALL be ignored.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, count=0, window entries=0, out_valid=0, out_num=0, out_last=0, short_frame=0.
REQ-031 in_ready SHALL read 1 during and after reset, since out_valid=0.
REQ-032 Reset mid-frame SHALL discard all held samples and any pending output; no output SHALL follow the deassertion of reset.

Structure
REQ-033 State enum (IDLE/FILL/RUN), DATA_W default and WIN constant SHALL live in a shared package median_pkg.
REQ-034 The median SHALL be computed by one combinational sub-module median5 (5 x DATA_W in, DATA_W out, compare-exchange network); the controller holds all registers.

Verification
REQ-035 Frame 7,3,9,1,5 (last on 5), out_ready=1 -> one output 5, out_last=1, one cycle after the 5th acceptance.
REQ-036 Frame 10,20,30,40,50,60,0 (last on 0), out_ready=1 -> outputs 30,40,40; only the final one has out_last=1.
REQ-037 Frame 4,8,2 (last on 2) -> no out_valid; short_frame pulses 1 cycle; the next frame 1,1,1,1,1 -> output 1.
REQ-038 Continuous frame with out_ready=0 held 3 cycles on the first median -> in_ready=0, out_num stable for those 3 cycles, no sample lost, and the median sequence is correct after release.
REQ-039 rst_n pulsed low after 3 samples of a frame -> outputs all zero; the following frame 63,0,63,0,63 -> output 63 with no contamination from the pre-reset samples.
